load_store_unit: RTL
====================

# load_store_unit

Multi-cycle RV32I load/store unit between the execute stage and the register-file write port. It accepts one memory operation at a time from execute, runs a req/ack transaction on the data-memory bus, aligns and sign-extends load data, and drives the register file's write port (`d`, `addr`, `we`) for loads. While a transaction is in flight it asserts `busy` so the pipeline stalls.

## Interface
Parameters:
- `XLEN`, 32, data/address width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `start`  in  1  execute issues an operation this cycle.
- `is_store`  in  1  1 = store (SB/SH/SW), 0 = load.
- `funct3`  in  3  RV32I funct3 of the operation.
- `base`  in  32  rs1 value (register-file `qa`).
- `offset`  in  32  sign-extended immediate.
- `store_data`  in  32  rs2 value (register-file `qb`).
- `rd`  in  5  load destination register.
- `busy`  out  1  operation in flight; execute must stall.
- `err`  out  1  one-cycle pulse: misaligned access or illegal funct3.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  32  word-aligned address; bits [1:0] are always 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  bus completion.
- `mem_rdata`  in  32  read data; valid only while `mem_ack` = 1.
- `wb_we`  out  1  register-file write enable.
- `wb_addr`  out  5  register-file write address.
- `wb_data`  out  32  register-file write data.

## Operation
- Effective address: `ea` = `base` + `offset` mod 2^32.
- State machine with three states: IDLE, REQ, WB.
- IDLE, `start` = 1, legal and aligned operation: capture `ea`, `funct3`, `rd`, `is_store`, and the lane-formatted store data and byte enables. Next state is REQ.
- IDLE, `start` = 1, illegal or misaligned operation: pulse `err` for one cycle and stay in IDLE. No bus request and no writeback.
  - Illegal loads: funct3 011, 110, 111.
  - Illegal stores: funct3 greater than 010.
  - Misaligned halfword: `ea[0]` = 1.
  - Misaligned word: `ea[1:0]` != 0.
- REQ: hold `mem_req` = 1 and all `mem_*` outputs stable until `mem_ack` = 1.
  - Store acknowledged: next state is IDLE.
  - Load acknowledged: register the aligned data; next state is WB.
- WB: `wb_we` = 1 for exactly one cycle, then IDLE. If `rd` = 0, `wb_we` stays 0 but the WB cycle still occurs.
- Store lanes:
  - SB: `mem_be` = 1 << `ea[1:0]`; `mem_wdata` = byte replicated ×4.
  - SH: `mem_be` = 0011 if `ea[1]` = 0, else 1100; `mem_wdata` = halfword replicated ×2.
  - SW: `mem_be` = 1111.
- Load extract: select the byte or halfword by `ea[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- For loads, `mem_be` = 1111.
- A `start` arriving while `busy` = 1 is ignored. Execute must not assert `start` while `busy` = 1.

## Timing
- Every output is registered.
- Reset values: `busy`, `err`, `mem_req`, `mem_we`, `wb_we` = 0; `mem_addr`, `mem_wdata`, `wb_data` = 0; `mem_be` = 0; `wb_addr` = 0. State = IDLE.
- `start` sampled at edge 0 → `mem_req` and `busy` are 1 from cycle 1.
- If `mem_ack` is high in the first REQ cycle (cycle 1), the transaction completes that cycle.
- Load, `mem_ack` at cycle k → `wb_we`/`wb_data` valid at cycle k+1; `busy` falls at k+2. Minimum load latency is 3 cycles, start to IDLE.
- Store, `mem_ack` at cycle k → `mem_req` and `busy` are 0 at k+1.
- `err` is high in the cycle after `start`; `busy` stays 0.
- Reset asserted mid-transaction: all outputs clear immediately, the transaction is abandoned, and no writeback occurs. A late `mem_ack` in IDLE is ignored.

## Structure
- Shared package `rv32_pkg` holds:
  - funct3 constants: F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - the state enum (IDLE, REQ, WB).
- Sub-module `lsu_align` (combinational) contains the store-lane formatting, the load extract/extension, and the misalign/illegal check. The top level holds the FSM and registers.

## Test plan
- LW: `base` = 0x100, `offset` = 4, `rd` = 5, `mem_ack` at cycle 3, `mem_rdata` = 0xDEADBEEF → `mem_addr` = 0x104, `mem_be` = 1111; cycle 4: `wb_we` = 1, `wb_addr` = 5, `wb_data` = 0xDEADBEEF.
- LB/LBU: `ea` = 0x203, `mem_rdata` = 0x80112233 → LB `wb_data` = 0xFFFFFF80; LBU `wb_data` = 0x00000080. `mem_addr` = 0x200.
- SH: `ea` = 0x302, `store_data` = 0x1234ABCD → `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1; no `wb_we`.
- Misaligned LW at `ea` = 0x101, and funct3 = 011 load → `err` pulse one cycle; `mem_req` and `busy` stay 0.
- LW with `rd` = 0 and `mem_ack` delayed 5 cycles → `mem_req` held with stable outputs throughout; `wb_we` stays 0; `busy` is 1 for 7 cycles.
- `clr` low while in REQ → `mem_req` and `busy` are 0 immediately; a subsequent `mem_ack` produces no writeback.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the load/store path.
// funct3 encodings and the LSU state type.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WB
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check,
// store lane formatting and load extract/extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    output logic        ok,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic        legal;
    logic        aligned;
    logic [31:0] sh;

    // Legal funct3 for the direction, and natural alignment by size.
    always_comb begin
        legal = 1'b0;
        if (is_store)
            legal = funct3 inside {F3_B, F3_H, F3_W};
        else
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~ea_lo[0];
            2'b10:   aligned = (ea_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        ok = legal & aligned;
    end

    // Byte enables and replicated write data; loads read the whole word.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << ea_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = ea_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
        if (!is_store)
            be = 4'b1111;
    end

    // Shift the addressed lane down, then sign or zero extend.
    always_comb begin
        sh = rdata >> {ld_lo, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   ld_data = {24'd0, sh[7:0]};
            F3_HU:   ld_data = {16'd0, sh[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one bus transaction
// at a time, registered outputs, load writeback port.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    lsu_state_t  state;
    lsu_state_t  state_n;
    logic [31:0] ea;
    logic        ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [4:0]  rd_q;
    logic        st_q;
    logic        accept;
    logic        done;

    assign ea     = base + offset;
    assign accept = (state == IDLE) && start && ok;
    assign done   = (state == REQ) && mem_ack;

    lsu_align u_align (
        .is_store   (is_store),
        .funct3     (funct3),
        .ea_lo      (ea[1:0]),
        .store_data (store_data),
        .ok         (ok),
        .be         (be),
        .wdata      (wdata),
        .ld_funct3  (f3_q),
        .ld_lo      (lo_q),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state: accept, wait for ack, one writeback cycle for loads.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = REQ;
            REQ:     if (mem_ack) state_n = st_q ? IDLE : WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs and captured operation.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            wb_we     <= 1'b0;
            wb_addr   <= 5'd0;
            wb_data   <= '0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
            rd_q      <= 5'd0;
            st_q      <= 1'b0;
        end else begin
            busy    <= (state_n != IDLE);
            mem_req <= (state_n == REQ);
            err     <= (state == IDLE) && start && !ok;
            wb_we   <= done && !st_q && (rd_q != 5'd0);
            if (accept) begin
                mem_addr  <= {ea[31:2], 2'b00};
                mem_we    <= is_store;
                mem_be    <= be;
                mem_wdata <= wdata;
                f3_q      <= funct3;
                lo_q      <= ea[1:0];
                rd_q      <= rd;
                st_q      <= is_store;
            end
            if (done && !st_q) begin
                wb_addr <= rd_q;
                wb_data <= ld_data;
            end
        end
    end

endmodule
